la_capture_fsm: RTL and testbench
=================================

# la_capture_fsm

Capture sequencer for the logic analyzer. It arms on a host request and fills the sample ring buffer with a programmable number of pre-trigger samples. It then waits for the combined `trig` output of the trigger blocks and captures post-trigger samples until the buffer holds exactly `SAMPLE_DEPTH` samples. It sits between the host register interface, the trigger blocks, and the sample-memory write port, and it reports state, write address and oldest-sample address for readback.

## Interface
- `SAMPLE_DEPTH`, default 4096: ring buffer depth in samples. Must be a power of two and ≥ 2.
- `ADDR_WIDTH`, default `$clog2(SAMPLE_DEPTH)`: derived. Not overridden.

Ports:
- `clk` in 1: single clock. All state changes on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: arm request, one-cycle pulse from the host.
- `stop_req` in 1: abort request, one-cycle pulse.
- `trigger_loc` in ADDR_WIDTH: number of pre-trigger samples. Latched on accepted `start`.
- `trig` in 1: combined trigger condition, valid in the same cycle as the current probe sample.
- `state` out 3: current state code (see Structure).
- `bram_we` out 1: sample-memory write enable.
- `write_ptr` out ADDR_WIDTH: sample-memory write address.
- `read_ptr` out ADDR_WIDTH: address of the oldest retained sample.
- `done` out 1: capture complete.

## Operation
- **States:** IDLE=0, MOVE_TO_POSITION=1, IN_POSITION=2, CAPTURING=3, CAPTURED=4.
- **Write enable:** `bram_we` = state ∈ {MOVE_TO_POSITION, IN_POSITION, CAPTURING}. Combinational from the registered state.
- **Write address and wrap:** while `bram_we` is high, the sample is written at `write_ptr`. All pointer arithmetic is modulo `SAMPLE_DEPTH` (natural ADDR_WIDTH wrap).
- **IDLE:**
  - `start` → `loc_q`←`trigger_loc`, `write_ptr`←0, `read_ptr`←0.
  - Next state is MOVE_TO_POSITION if `trigger_loc`≠0, else IN_POSITION.
- **MOVE_TO_POSITION:**
  - `write_ptr`++ each cycle; `trig` is ignored.
  - In the cycle where `write_ptr`==`loc_q`−1 → IN_POSITION.
  - Exactly `loc_q` samples are written.
- **IN_POSITION, `trig`=0:** `write_ptr`++ and `read_ptr`++. This keeps the last `loc_q` samples in [`read_ptr`, `write_ptr`).
- **IN_POSITION, `trig`=1:**
  - The current sample (the trigger sample) is written; `write_ptr`++; `read_ptr` holds.
  - Next state is CAPTURING, or CAPTURED if `write_ptr`+1==`read_ptr` (the case `loc_q`=`SAMPLE_DEPTH`−1).
- **CAPTURING:**
  - `write_ptr`++ each cycle.
  - In the cycle where `write_ptr`+1==`read_ptr` (last free slot written) → CAPTURED.
  - `trig` is ignored.
- **CAPTURED:**
  - `bram_we`=0, `done`=1, pointers frozen.
  - Buffer holds `SAMPLE_DEPTH` samples starting at `read_ptr`; the trigger sample is at `read_ptr`+`loc_q`.
  - `start` re-arms exactly as from IDLE.
- **Start elsewhere:** `start` in states 1–3 is ignored.
- **`stop_req`:** in any state → IDLE next cycle. Pointers hold. Priority over `start` and `trig` in the same cycle.
- **`trigger_loc` changes:** changes after arming have no effect until the next accepted `start`.

## Timing
- **Reset values:** `rst_n`=0 at an edge → state=IDLE, `write_ptr`=0, `read_ptr`=0, `loc_q`=0, `bram_we`=0, `done`=0. This holds mid-capture; no write occurs in the reset cycle's successor.
- **Arming latency:** `start` accepted at edge N → first write in cycle N+1.
- **Pre-trigger fill:** IN_POSITION is reached `loc_q` cycles after the first write.
- **`trig` sampling:** sampled only in IN_POSITION, in the same cycle as the sample it qualifies; no pipelining.
- **Capture length:** trigger at cycle T → CAPTURED at cycle T+(`SAMPLE_DEPTH`−`loc_q`). `done` rises in that cycle.
- **`done`:** a registered state decode, high exactly while state==CAPTURED.

## Structure
- Shared package `la_pkg`: state codes (IDLE…CAPTURED) and the 3-bit state width. Host register map and bench decode `state` from these.
- No sub-module. Pointers are plain ADDR_WIDTH registers using natural wrap. The trigger-block OR-reduction lives outside this block.

## Test plan
All scenarios use `SAMPLE_DEPTH`=8.
- **Reset mid-capture:** `rst_n` low during CAPTURING → next cycle state=0, `bram_we`=0, `write_ptr`=0, `read_ptr`=0, `done`=0.
- **Normal capture:** `trigger_loc`=3, `start`, `trig` held 0 for 6 IN_POSITION cycles then pulsed.
  - Required: 3 MOVE writes at 0,1,2; IN_POSITION writes at 3..7,0 with `read_ptr` ending at 6; trigger written at 1.
  - Then 4 CAPTURING writes at 2..5; CAPTURED with `read_ptr`=6, `done`=1, 8 writes total after trigger-window fill.
- **Zero pre-trigger:** `trigger_loc`=0, `trig` high in the first cycle after `start`.
  - Required: state goes IDLE→IN_POSITION directly; trigger at addr 0; CAPTURED after 8 writes total, `read_ptr`=0.
- **Maximum pre-trigger:** `trigger_loc`=7, `trig` in the first IN_POSITION cycle.
  - Required: 7 MOVE writes, the trigger write at 7, then CAPTURED directly (CAPTURING skipped), `read_ptr`=0.
- **Abort and ignore:** `stop_req` and `trig` in the same IN_POSITION cycle → IDLE next cycle, no further writes; `start` during CAPTURING → ignored.
- **Re-arm:** `start` while CAPTURED with `trigger_loc`=2 → pointers reset to 0, `done` drops next cycle, MOVE writes at 0,1.

Source files
------------

// File: rtl/la_pkg.sv
// Shared state encoding for the logic-analyzer capture sequencer.
// Host register map and benches decode the capture state from these codes.
package la_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE             = 3'd0,
    ST_MOVE_TO_POSITION = 3'd1,
    ST_IN_POSITION      = 3'd2,
    ST_CAPTURING        = 3'd3,
    ST_CAPTURED         = 3'd4
  } la_state_e;

endpackage

// File: rtl/la_capture_fsm.sv
// Capture sequencer: pre-trigger fill, trigger wait, post-trigger fill of a
// power-of-two sample ring buffer; pointers wrap naturally at ADDR_WIDTH.
module la_capture_fsm
  import la_pkg::*;
#(
  parameter int unsigned SAMPLE_DEPTH = 4096,
  parameter int unsigned ADDR_WIDTH   = $clog2(SAMPLE_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop_req,
  input  logic [ADDR_WIDTH-1:0] trigger_loc,
  input  logic                  trig,
  output logic [STATE_W-1:0]    state,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] write_ptr,
  output logic [ADDR_WIDTH-1:0] read_ptr,
  output logic                  done
);

  la_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wp_q, wp_d;
  logic [ADDR_WIDTH-1:0] rp_q, rp_d;
  logic [ADDR_WIDTH-1:0] loc_q, loc_d;
  logic [ADDR_WIDTH-1:0] wp_inc;

  assign wp_inc = wp_q + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      loc_q   <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      loc_q   <= loc_d;
    end
  end

  // Next state and pointer updates; stop_req overrides everything, pointers hold.
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    loc_d   = loc_q;
    if (stop_req) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_CAPTURED: begin
          if (start) begin
            loc_d   = trigger_loc;
            wp_d    = '0;
            rp_d    = '0;
            state_d = (trigger_loc != '0) ? ST_MOVE_TO_POSITION : ST_IN_POSITION;
          end
        end
        ST_MOVE_TO_POSITION: begin
          wp_d = wp_inc;
          if (wp_q == (loc_q - ADDR_WIDTH'(1))) state_d = ST_IN_POSITION;
        end
        ST_IN_POSITION: begin
          wp_d = wp_inc;
          if (trig) begin
            // Full window already behind the trigger when wp wraps onto rp.
            state_d = (wp_inc == rp_q) ? ST_CAPTURED : ST_CAPTURING;
          end else begin
            rp_d = rp_q + ADDR_WIDTH'(1);
          end
        end
        ST_CAPTURING: begin
          wp_d = wp_inc;
          if (wp_inc == rp_q) state_d = ST_CAPTURED;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign state     = state_q;
  assign bram_we   = (state_q == ST_MOVE_TO_POSITION) ||
                     (state_q == ST_IN_POSITION) ||
                     (state_q == ST_CAPTURING);
  assign done      = (state_q == ST_CAPTURED);
  assign write_ptr = wp_q;
  assign read_ptr  = rp_q;

endmodule

// File: tb/tb_la_capture_fsm.sv
// Self-checking bench for la_capture_fsm at SAMPLE_DEPTH=8; expected write
// addresses are queued by each scenario and consumed by a write monitor.
module tb_la_capture_fsm;
  import la_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop_req;
  logic [AW-1:0] trigger_loc;
  logic          trig;
  logic [2:0]    state;
  logic          bram_we;
  logic [AW-1:0] write_ptr;
  logic [AW-1:0] read_ptr;
  logic          done;

  int vectors = 0;
  int errors  = 0;
  logic [AW-1:0] exp_wr_q[$];

  la_capture_fsm #(.SAMPLE_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop_req(stop_req),
    .trigger_loc(trigger_loc), .trig(trig), .state(state),
    .bram_we(bram_we), .write_ptr(write_ptr), .read_ptr(read_ptr), .done(done)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_range(input int first, input int count);
    for (int i = 0; i < count; i++) exp_wr_q.push_back(AW'((first + i) % DEPTH));
  endtask

  // Write monitor: every write must match the next queued address; done tracks CAPTURED.
  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      vectors++;
      if (exp_wr_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d state=%0d, no write expected", write_ptr, state);
      end else begin
        logic [AW-1:0] e;
        e = exp_wr_q.pop_front();
        if (write_ptr !== e) begin
          errors++;
          $display("FAIL write_addr: got %0d expected %0d", write_ptr, e);
        end
      end
    end
    if (rst_n === 1'b1) begin
      vectors++;
      if (done !== (state == 3'(ST_CAPTURED))) begin
        errors++;
        $display("FAIL done_decode: done=%0b state=%0d", done, state);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop_req = 1'b0; trig = 1'b0; trigger_loc = '0;
    step(2);
    vectors++;
    if ({state, bram_we, write_ptr, read_ptr, done} !== {3'd0, 1'b0, 3'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: state=%0d we=%0b wp=%0d rp=%0d done=%0b expected all zero",
               state, bram_we, write_ptr, read_ptr, done);
    end
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_normal_capture();
    trigger_loc = 3'd3; start = 1'b1;
    push_range(0, 3);   // pre-trigger fill
    push_range(3, 6);   // rolling window 3..7,0
    push_range(1, 1);   // trigger sample
    push_range(2, 4);   // post-trigger
    step(1);
    start = 1'b0;
    vectors++;
    if (state !== 3'd1 || write_ptr !== 3'd0) begin
      errors++;
      $display("FAIL normal_arm: state=%0d wp=%0d expected state=1 wp=0", state, write_ptr);
    end
    step(3);
    vectors++;
    if (state !== 3'd2 || write_ptr !== 3'd3 || read_ptr !== 3'd0) begin
      errors++;
      $display("FAIL normal_in_pos: state=%0d wp=%0d rp=%0d expected 2/3/0", state, write_ptr, read_ptr);
    end
    step(6);
    vectors++;
    if (state !== 3'd2 || write_ptr !== 3'd1 || read_ptr !== 3'd6) begin
      errors++;
      $display("FAIL normal_window: state=%0d wp=%0d rp=%0d expected 2/1/6", state, write_ptr, read_ptr);
    end
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    vectors++;
    if (state !== 3'd3 || write_ptr !== 3'd2 || read_ptr !== 3'd6 || done !== 1'b0) begin
      errors++;
      $display("FAIL normal_trig: state=%0d wp=%0d rp=%0d done=%0b expected 3/2/6/0",
               state, write_ptr, read_ptr, done);
    end
    step(3);
    vectors++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL normal_capturing: state=%0d expected 3", state);
    end
    step(1);
    vectors++;
    if (state !== 3'd4 || read_ptr !== 3'd6 || write_ptr !== 3'd6 || done !== 1'b1) begin
      errors++;
      $display("FAIL normal_captured: state=%0d wp=%0d rp=%0d done=%0b expected 4/6/6/1",
               state, write_ptr, read_ptr, done);
    end
    step(2);
    vectors++;
    if (exp_wr_q.size() != 0 || state !== 3'd4) begin
      errors++;
      $display("FAIL normal_drain: pending=%0d state=%0d expected 0 pending, state 4",
               exp_wr_q.size(), state);
    end
  endtask

  task automatic test_rearm();
    trigger_loc = 3'd2; start = 1'b1;
    push_range(0, 2);
    push_range(2, 1);
    step(1);
    start = 1'b0;
    trigger_loc = 3'd7;   // must not affect the armed capture
    vectors++;
    if (state !== 3'd1 || write_ptr !== 3'd0 || read_ptr !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rearm: state=%0d wp=%0d rp=%0d done=%0b expected 1/0/0/0",
               state, write_ptr, read_ptr, done);
    end
    step(2);
    vectors++;
    if (state !== 3'd2 || write_ptr !== 3'd2) begin
      errors++;
      $display("FAIL rearm_loc_latched: state=%0d wp=%0d expected 2/2", state, write_ptr);
    end
    stop_req = 1'b1;
    step(1);
    stop_req = 1'b0;
    step(1);
  endtask

  task automatic test_zero_pretrigger();
    trigger_loc = 3'd0; start = 1'b1;
    push_range(0, 8);
    step(1);
    start = 1'b0;
    vectors++;
    if (state !== 3'd2 || write_ptr !== 3'd0 || read_ptr !== 3'd0) begin
      errors++;
      $display("FAIL zero_direct: state=%0d wp=%0d rp=%0d expected 2/0/0", state, write_ptr, read_ptr);
    end
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    step(6);
    vectors++;
    if (state !== 3'd3 || write_ptr !== 3'd7) begin
      errors++;
      $display("FAIL zero_capturing: state=%0d wp=%0d expected 3/7", state, write_ptr);
    end
    step(1);
    vectors++;
    if (state !== 3'd4 || read_ptr !== 3'd0 || done !== 1'b1 || exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL zero_captured: state=%0d rp=%0d done=%0b pending=%0d expected 4/0/1/0",
               state, read_ptr, done, exp_wr_q.size());
    end
  endtask

  task automatic test_max_pretrigger();
    trigger_loc = 3'd7; start = 1'b1;
    push_range(0, 8);
    step(1);
    start = 1'b0;
    step(6);
    vectors++;
    if (state !== 3'd1 || write_ptr !== 3'd6) begin
      errors++;
      $display("FAIL max_move: state=%0d wp=%0d expected 1/6", state, write_ptr);
    end
    step(1);
    vectors++;
    if (state !== 3'd2 || write_ptr !== 3'd7 || read_ptr !== 3'd0) begin
      errors++;
      $display("FAIL max_in_pos: state=%0d wp=%0d rp=%0d expected 2/7/0", state, write_ptr, read_ptr);
    end
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    vectors++;
    if (state !== 3'd4 || read_ptr !== 3'd0 || done !== 1'b1) begin
      errors++;
      $display("FAIL max_captured: state=%0d rp=%0d done=%0b expected 4/0/1", state, read_ptr, done);
    end
    step(2);
    vectors++;
    if (exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL max_drain: pending=%0d expected 0", exp_wr_q.size());
    end
  endtask

  task automatic test_abort();
    trigger_loc = 3'd2; start = 1'b1;
    push_range(0, 3);
    step(1);
    start = 1'b0;
    step(2);
    trig = 1'b1; stop_req = 1'b1;
    step(1);
    trig = 1'b0; stop_req = 1'b0;
    vectors++;
    if (state !== 3'd0 || write_ptr !== 3'd2 || read_ptr !== 3'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort: state=%0d wp=%0d rp=%0d done=%0b expected 0/2/0/0",
               state, write_ptr, read_ptr, done);
    end
    step(3);
    vectors++;
    if (state !== 3'd0 || exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL abort_idle: state=%0d pending=%0d expected 0/0", state, exp_wr_q.size());
    end
  endtask

  task automatic test_reset_mid_capture();
    trigger_loc = 3'd0; start = 1'b1;
    push_range(0, 4);
    step(1);
    start = 1'b0;
    trig = 1'b1;
    step(1);
    trig = 1'b0;
    start = 1'b1; trigger_loc = 3'd5;   // ignored while capturing
    step(1);
    start = 1'b0;
    vectors++;
    if (state !== 3'd3 || write_ptr !== 3'd2 || read_ptr !== 3'd0) begin
      errors++;
      $display("FAIL start_ignored: state=%0d wp=%0d rp=%0d expected 3/2/0", state, write_ptr, read_ptr);
    end
    step(1);
    rst_n = 1'b0;
    step(1);
    vectors++;
    if ({state, bram_we, write_ptr, read_ptr, done} !== {3'd0, 1'b0, 3'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: state=%0d we=%0b wp=%0d rp=%0d done=%0b expected all zero",
               state, bram_we, write_ptr, read_ptr, done);
    end
    rst_n = 1'b1;
    step(2);
    vectors++;
    if (state !== 3'd0 || exp_wr_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: state=%0d pending=%0d expected 0/0", state, exp_wr_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_normal_capture();
    test_rearm();
    test_zero_pretrigger();
    test_max_pretrigger();
    test_abort();
    test_reset_mid_capture();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
